// File: rtl/add_sub_iter.sv
// Iterative 32-bit adder/subtractor, DIGIT_W bits per cycle, LSB first.
// Produces the result plus the sign/carry/zero flag set for the branch comparator.
module add_sub_iter #(
    parameter int DIGIT_W = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        sub_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o,
    output logic        a_31_o,
    output logic        b_31_o,
    output logic        diff_31_o,
    output logic        carry_o,
    output logic        zero_o
);

    localparam int N     = 32 / DIGIT_W;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_sh_q, a_sh_d;
    logic [31:0]        b_sh_q, b_sh_d;
    logic [31:0]        res_sh_q, res_sh_d;
    logic               carry_acc_q, carry_acc_d;
    logic               zero_acc_q, zero_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_sign_q, a_sign_d;
    logic               b_sign_q, b_sign_d;

    logic [31:0]        result_q, result_d;
    logic               a_31_q, a_31_d;
    logic               b_31_q, b_31_d;
    logic               diff_31_q, diff_31_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;

    logic [DIGIT_W:0]       digit_sum;
    logic [31+DIGIT_W:0]    res_cat;
    logic [31:0]            res_next;
    logic                   digit_zero;

    // Concatenating before slicing keeps the shift legal even when DIGIT_W = 32.
    assign digit_sum  = {1'b0, a_sh_q[DIGIT_W-1:0]} + {1'b0, b_sh_q[DIGIT_W-1:0]}
                      + {{DIGIT_W{1'b0}}, carry_acc_q};
    assign res_cat    = {digit_sum[DIGIT_W-1:0], res_sh_q};
    assign res_next   = res_cat[31+DIGIT_W:DIGIT_W];
    assign digit_zero = (digit_sum[DIGIT_W-1:0] == '0);

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        carry_acc_d = carry_acc_q;
        zero_acc_d  = zero_acc_q;
        cnt_d       = cnt_q;
        a_sign_d    = a_sign_q;
        b_sign_d    = b_sign_q;
        result_d    = result_q;
        a_31_d      = a_31_q;
        b_31_d      = b_31_q;
        diff_31_d   = diff_31_q;
        carry_d     = carry_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    a_sh_d      = a_i;
                    b_sh_d      = sub_i ? ~b_i : b_i;
                    carry_acc_d = sub_i;
                    zero_acc_d  = 1'b1;
                    cnt_d       = '0;
                    a_sign_d    = a_i[31];
                    b_sign_d    = b_i[31];
                    state_d     = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d      = a_sh_q >> DIGIT_W;
                b_sh_d      = b_sh_q >> DIGIT_W;
                res_sh_d    = res_next;
                carry_acc_d = digit_sum[DIGIT_W];
                zero_acc_d  = zero_acc_q & digit_zero;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    result_d  = res_next;
                    carry_d   = digit_sum[DIGIT_W];
                    zero_d    = zero_acc_q & digit_zero;
                    diff_31_d = res_next[31];
                    a_31_d    = a_sign_q;
                    b_31_d    = b_sign_q;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            carry_acc_q <= 1'b0;
            zero_acc_q  <= 1'b0;
            cnt_q       <= '0;
            a_sign_q    <= 1'b0;
            b_sign_q    <= 1'b0;
            result_q    <= '0;
            a_31_q      <= 1'b0;
            b_31_q      <= 1'b0;
            diff_31_q   <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            carry_acc_q <= carry_acc_d;
            zero_acc_q  <= zero_acc_d;
            cnt_q       <= cnt_d;
            a_sign_q    <= a_sign_d;
            b_sign_q    <= b_sign_d;
            result_q    <= result_d;
            a_31_q      <= a_31_d;
            b_31_q      <= b_31_d;
            diff_31_q   <= diff_31_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign result_o  = result_q;
    assign a_31_o    = a_31_q;
    assign b_31_o    = b_31_q;
    assign diff_31_o = diff_31_q;
    assign carry_o   = carry_q;
    assign zero_o    = zero_q;

endmodule

// File: doc/add_sub_iter.md
# add_sub_iter

Iterative 32-bit adder/subtractor for the multicycle datapath. It processes DIGIT_W bits per cycle, LSB first. It produces the sum or difference together with the flag set the branch comparator consumes: operand sign bits, result sign, carry-out and zero. A start/done handshake hands the registered flags downstream. The flags hold stable until the next operation completes, so the comparator can evaluate them in any later FSM state.

## Interface
- DIGIT_W, 4: bits processed per cycle. Legal values are 1, 2, 4, 8, 16 and 32, i.e. values that divide 32. N = 32/DIGIT_W cycles per operation.
- clk_i  in  1  clock. All flops trigger on the rising edge.
- rst_ni  in  1  reset. Asynchronous, active-low.
- start_i  in  1  request. Sampled only when the block is accepting (IDLE or DONE).
- sub_i  in  1  1 = a_i − b_i, 0 = a_i + b_i. Sampled with start_i.
- a_i  in  32  operand A. Sampled with start_i.
- b_i  in  32  operand B. Sampled with start_i.
- busy_o  out  1  high while an operation is in flight (RUN).
- done_o  out  1  one-cycle pulse. Result and flags are updated when it is high.
- result_o  out  32  sum or difference.
- a_31_o  out  1  bit 31 of the captured a_i.
- b_31_o  out  1  bit 31 of the captured b_i, uninverted.
- diff_31_o  out  1  result_o[31].
- carry_o  out  1  carry-out of bit 31. For subtraction, 1 = no borrow (a ≥ b unsigned).
- zero_o  out  1  1 when result_o == 0.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE/DONE with start_i = 1: capture the following, then go to RUN.
  - A into a_sh.
  - B, or ~B when sub_i = 1, into b_sh.
  - Carry register set to sub_i.
  - zero accumulator set to 1.
  - Digit counter set to 0.
  - Sign bits a_i[31] and b_i[31].
- IDLE/DONE with start_i = 0: go to IDLE.
- RUN, each cycle:
  - Add the low DIGIT_W bits of a_sh and b_sh plus the carry, giving a (DIGIT_W+1)-bit sum.
  - Shift the low DIGIT_W sum bits into the top of res_sh, which shifts right.
  - Shift a_sh and b_sh right by DIGIT_W.
  - Carry register takes sum bit DIGIT_W.
  - zero accumulator &= (digit == 0).
  - Counter increments.
- RUN, final digit (counter == N−1):
  - Transfer res_sh with the final digit, the final carry and the final zero accumulator into the output registers.
  - Load a_31_o and b_31_o from the captured sign bits.
  - diff_31_o = final result bit 31.
  - Go to DONE.
- DONE lasts exactly one cycle. It returns to IDLE, or to RUN when start_i is high.
- start_i while in RUN is ignored. No queuing.
- Outputs are not cleared at start. They change only on the final-digit transfer.
- All arithmetic is modulo 2^32. No overflow flag; signed comparison is derived downstream from the sign bits and diff_31_o.

## Timing
- Reset (rst_ni low, any state, including mid-RUN) forces the following immediately:
  - State = IDLE.
  - busy_o = 0, done_o = 0.
  - result_o = 0, a_31_o = 0, b_31_o = 0, diff_31_o = 0, carry_o = 0, zero_o = 0.
  - Counter = 0.
- An operation aborted by reset produces no done_o and leaves no partial output.
- Latency: start_i is sampled at edge E0. busy_o is high from E0 to E_N. done_o is high from E_N to E_N+1 (N = 8 for DIGIT_W = 4).
- result_o and flags change at E_N and are valid in the same cycle that done_o is high.
- Back-to-back: start_i high during the DONE cycle is accepted at E_N+1. Throughput is then one operation every N+1 cycles.
- DIGIT_W = 32: a single RUN cycle. done_o is high from E1 to E2.
- done_o and busy_o are never high in the same cycle.

## Test plan
- sub: a=5, b=3 -> done_o high exactly 8 cycles after start, single pulse. result_o=2, carry_o=1, zero_o=0, diff_31_o=0. busy_o high for 8 cycles.
- sub: a=b=0x8000_0000 -> result_o=0, zero_o=1, carry_o=1, a_31_o=1, b_31_o=1.
- sub: a=1, b=2 -> result_o=0xFFFF_FFFF, carry_o=0, diff_31_o=1, zero_o=0. Outputs hold unchanged for 20 idle cycles while a_i and b_i toggle randomly.
- add: a=0xFFFF_FFFF, b=1 -> result_o=0, carry_o=1, zero_o=1.
  - Then add a=0x7FFF_FFFF, b=1 -> result_o=0x8000_0000, carry_o=0, diff_31_o=1.
- Handshake:
  - start_i asserted again at cycle 3 of RUN is ignored; exactly one done_o results.
  - start_i held high through DONE launches the next op; the second done_o comes 9 cycles after the first.
- Reset mid-op: rst_ni low at RUN cycle 4 -> immediately busy_o=0 and all outputs 0. No done_o follows. A subsequent sub of a=10, b=10 gives zero_o=1, carry_o=1 after 8 cycles.
